ctrl_uart_tx_fifo: RTL
======================

Name: ctrl_uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter for the control CPU's debug console, on the qmem bus.
- Sits directly downstream of the control register decode. Each write to the UART TX register pushes one byte into a FIFO. A serializer drains the FIFO onto uart_txd.
- Removes the one-byte-at-a-time stall: the CPU is held off only when the FIFO is full.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW = 16 entries.
- TXD_CNT, 434: clocks per bit; 434 gives 115200 baud at 50 MHz. Legal range 2..65535.
- CW, 16: width of the baud counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- cs  in  1  qmem chip select for the TX register.
- we  in  1  qmem write enable.
- dat_w  in  8  byte to transmit (qmem dat_w[7:0]).
- ack  out  1  qmem acknowledge.
- err  out  1  qmem error; always 0.
- flush  in  1  one-cycle pulse that discards all queued bytes.
- fifo_level  out  FIFO_AW+1  number of queued bytes, 0..16.
- fifo_full  out  1  fifo_level == 2**FIFO_AW.
- fifo_empty  out  1  fifo_level == 0.
- tx_busy  out  1  a frame is being shifted out.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Reset (rst == 0 at a clk edge): values after that edge:
  - read/write pointers = 0; fifo_level = 0; fifo_empty = 1; fifo_full = 0.
  - tx_busy = 0; uart_txd = 1; serializer in IDLE.
- Reset mid-frame: the frame aborts; uart_txd is high after the reset edge. The FIFO contents are lost.
- Push:
  - A push occurs when cs && we && !fifo_full.
  - The byte is stored at the write pointer; the pointer increments and wraps modulo 2**FIFO_AW.
- ack:
  - When cs && we: ack = !fifo_full (combinational). A blocked write stalls the master until space frees.
  - Otherwise: ack = 1.
- Pointer and level rules:
  - Pointers are FIFO_AW+1 bits wide, with the MSB used as the wrap bit.
  - level = wr_ptr - rd_ptr.
  - full = equal low bits and different MSB; empty = pointers equal.
- Push and pop in the same cycle: both occur and the level is unchanged.
- Push while full: not accepted, even if a pop occurs that same cycle. Full is evaluated on registered state.
- flush:
  - Sets rd_ptr = wr_ptr. Takes priority over a simultaneous push; that push is dropped, and ack still follows !fifo_full for that cycle.
  - Does not abort the frame in flight.
- Serializer state machine: IDLE -> SHIFT -> IDLE.
  - IDLE: uart_txd = 1, tx_busy = 0. If !fifo_empty (and CTS permits, see Optional Feature):
    - pop the head byte;
    - load shift register = {1, byte, 0}, LSB first;
    - bit count = 9; baud counter = TXD_CNT-1;
    - go to SHIFT.
  - SHIFT: uart_txd = shift_reg[0]; tx_busy = 1.
    - The baud counter decrements each clock.
    - At 0 with bit count > 0: shift right filling 1, bit count -1, reload baud counter.
    - At 0 with bit count == 0 (last stop-bit cycle): if FIFO non-empty (and CTS permits), pop and reload a new frame directly, giving zero idle gap; else go to IDLE.
- Frame timing: exactly 10*TXD_CNT clocks (start, 8 data LSB-first, stop).
- First-byte latency (FIFO empty, serializer idle):
  - push at edge N; fifo_level = 1 after N.
  - pop at edge N+1; uart_txd falls after N+1.
  - fifo_level returns to 0 after N+1.
- Baud counter arithmetic: CW-bit unsigned, no wrap (reloaded at 0).

Optional Feature:
- Macro: CTRL_UART_TX_CTS_EN.
- Defined:
  - Adds input cts_n (1 bit, active-low clear-to-send), passed through a 2-flop synchronizer.
  - A pop (from IDLE or back-to-back) is allowed only while the synchronized cts_n == 0.
  - A frame already started always completes.
  - Reset value of both synchronizer flops = 1 (blocked).
- Undefined: no cts_n port; pops depend only on FIFO state.

Test Plan (TXD_CNT = 4, FIFO_AW = 2 unless noted):
1. Reset, then push 0xA5 -> uart_txd after the pop edge is, at 4 clocks per bit: 0,1,0,1,0,0,1,0,1,1; tx_busy high for exactly 40 clocks; fifo_level 1 -> 0.
2. Push 0x01, 0x02, 0x03 back-to-back -> three frames with no idle clock between stop and next start; total 120 busy clocks.
3. Push 6 bytes in consecutive write cycles, with the first pop removing one byte:
   - the 6th write sees ack = 0 until the first frame ends and a pop frees a slot;
   - fifo_full = 1 and fifo_level = 4 while stalled;
   - no byte is lost or duplicated.
4. Queue 3 bytes, pulse flush mid-frame 1 -> frame 1 completes intact; fifo_level = 0 after the flush edge; no further frames.
5. Drive rst = 0 for one cycle during the data bits of a frame -> uart_txd = 1 and tx_busy = 0 after that edge; fifo_empty = 1; a subsequent push of 0x5A transmits correctly.
6. With CTRL_UART_TX_CTS_EN, cts_n = 1, push 0x55 -> no start bit while cts_n stays high; drive cts_n = 0 -> start bit exactly 3 clocks later (2 synchronizer flops + pop edge).

Source files
------------

// File: rtl/ctrl_uart_tx_fifo_if.sv
// ctrl_uart_tx_fifo_if: qmem write-port bundle for the UART TX register.
//   cs     chip select for the TX register
//   we     write enable
//   dat_w  byte to transmit
//   ack    acknowledge; low stalls the master (FIFO full)
//   err    bus error, always 0
// master: the register decode / CPU side. slave: ctrl_uart_tx_fifo.
interface ctrl_uart_tx_fifo_if;
  logic       cs;
  logic       we;
  logic [7:0] dat_w;
  logic       ack;
  logic       err;

  modport master (
    output cs,
    output we,
    output dat_w,
    input  ack,
    input  err
  );

  modport slave (
    input  cs,
    input  we,
    input  dat_w,
    output ack,
    output err
  );
endinterface

// File: rtl/ctrl_uart_tx_fifo.sv
// ctrl_uart_tx_fifo: buffered 8N1 UART transmitter for the debug console.
// Each accepted qmem write queues one byte; a serializer drains the queue
// onto uart_txd LSB first, back-to-back with no idle gap between frames.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   cts_n       clear-to-send, active low (only with CTRL_UART_TX_CTS_EN)
//   bus         qmem slave port (cs, we, dat_w, ack, err)
//   flush       one-cycle pulse discarding all queued bytes
//   fifo_level  queued byte count, 0..2**FIFO_AW
//   fifo_full   queue full
//   fifo_empty  queue empty
//   tx_busy     a frame is being shifted out
//   uart_txd    serial output, idle high
//
// Optional feature: define CTRL_UART_TX_CTS_EN to add cts_n flow control.
module ctrl_uart_tx_fifo #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned TXD_CNT = 434,
  parameter int unsigned CW      = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef CTRL_UART_TX_CTS_EN
  input  logic               cts_n,
`endif
  ctrl_uart_tx_fifo_if.slave bus,
  input  logic               flush,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic               tx_busy,
  output logic               uart_txd
);

  localparam int unsigned   Depth      = 2 ** FIFO_AW;
  localparam logic [CW-1:0] BaudReload = CW'(TXD_CNT - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [Depth];
  logic [7:0]       head;
  logic             push;
  logic             pop;
  logic             can_pop;
  logic             cts_ok;

  state_e           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    baud_q, baud_d;

  // ---------------------------------------------------------------------------
  // Optional clear-to-send gating
  // ---------------------------------------------------------------------------
`ifdef CTRL_UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Resets to "blocked" so nothing leaves before cts_n has been seen low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= {cts_sync_q[0], cts_n};
    end
  end

  assign cts_ok = !cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // Full is taken from registered state, so a pop in the same cycle does not
  // make room for a push. A flush drops any coincident push.
  assign push    = bus.cs && bus.we && !fifo_full && !flush;
  assign bus.ack = (bus.cs && bus.we) ? !fifo_full : 1'b1;
  assign bus.err = 1'b0;

  assign head    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign can_pop = !fifo_empty && cts_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(1);
    end
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + (FIFO_AW + 1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.dat_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (can_pop) begin
          pop       = 1'b1;
          shift_d   = {1'b1, head, 1'b0};
          bit_cnt_d = 4'd9;
          baud_d    = BaudReload;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (baud_q != '0) begin
          baud_d = baud_q - CW'(1);
        end else if (bit_cnt_q != 4'd0) begin
          shift_d   = {1'b1, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q - 4'd1;
          baud_d    = BaudReload;
        end else if (can_pop) begin
          // Last stop-bit cycle: chain straight into the next frame.
          pop       = 1'b1;
          shift_d   = {1'b1, head, 1'b0};
          bit_cnt_d = 4'd9;
          baud_d    = BaudReload;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= StIdle;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      baud_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
    end
  end

  assign tx_busy  = (state_q == StShift);
  assign uart_txd = (state_q == StShift) ? shift_q[0] : 1'b1;

endmodule
